// File: rtl/rv_ctrl_pkg.sv
// Shared control encodings for the multicycle RV32I sequencer: FSM states,
// opcode constants and the select/operation codes it drives onto the datapath.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH      = 3'd0,
        ST_FETCH_WAIT = 3'd1,
        ST_DECODE     = 3'd2,
        ST_EXECUTE    = 3'd3,
        ST_MEM_WAIT   = 3'd4,
        ST_WRITEBACK  = 3'd5,
        ST_TRAP       = 3'd6
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [1:0] PC_HOLD  = 2'b00;
    localparam logic [1:0] PC_PLUS4 = 2'b01;
    localparam logic [1:0] PC_REL   = 2'b10;
    localparam logic [1:0] PC_JALR  = 2'b11;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_IMM  = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_BUS     = 2'b10;

    function automatic logic is_mem_opcode(input logic [6:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU-operation decode from the IR fields; flags any opcode or
// funct7 combination outside RV32I as illegal.
module alu_decoder
    import rv_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_op,
    output logic       illegal
);

    // Immediate shifts carry the shift amount in the low funct7 bits on RV64,
    // so only the bits above the shamt field take part in the legality check.
    localparam logic [6:0] SHIFT_F7_MASK = (XLEN == 64) ? 7'b1111110 : 7'b1111111;

    logic [6:0] shift_f7;
    assign shift_f7 = funct7 & SHIFT_F7_MASK;

    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  alu_op = ALU_ADD;
                        3'b001:  alu_op = ALU_SLL;
                        3'b010:  alu_op = ALU_SLT;
                        3'b011:  alu_op = ALU_SLTU;
                        3'b100:  alu_op = ALU_XOR;
                        3'b101:  alu_op = ALU_SRL;
                        3'b110:  alu_op = ALU_OR;
                        default: alu_op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    alu_op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    alu_op = ALU_SRA;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                case (funct3)
                    3'b000: alu_op = ALU_ADD;
                    3'b001: begin
                        alu_op  = ALU_SLL;
                        illegal = (shift_f7 != F7_BASE);
                    end
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b101: begin
                        if (shift_f7 == F7_BASE) begin
                            alu_op = ALU_SRL;
                        end else if (shift_f7 == F7_ALT) begin
                            alu_op = ALU_SRA;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    3'b110:  alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            OPC_BRANCH: alu_op = ALU_SUB;
            OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: alu_op = ALU_ADD;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle RV32I control sequencer: walks each instruction through
// fetch, decode, execute, optional memory wait and write-back, trapping on faults.
module multicycle_sequencer
    import rv_ctrl_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_load,
    output logic [1:0]       pc_sel,
    output logic [3:0]       alu_op,
    output logic             alu_src_imm,
    output logic [1:0]       wb_sel,
    output logic             rf_we,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT);

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               trap_q, trap_d;
    logic [1:0]         cause_q, cause_d;
    logic               mem_op_q, mem_op_d;
    logic               store_q, store_d;
    logic               taken_q, taken_d;

    logic [3:0] dec_alu_op;
    logic       dec_illegal;

    alu_decoder #(
        .XLEN(XLEN)
    ) u_alu_decoder (
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .alu_op (dec_alu_op),
        .illegal(dec_illegal)
    );

    logic is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_op;
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_lui    = (opcode == OPC_LUI);
    assign is_op     = (opcode == OPC_OP);

    logic       src_imm;
    logic [1:0] wb_code;
    logic [1:0] pc_code;

    assign src_imm = !(is_op || is_branch);

    always_comb begin
        wb_code = WB_ALU;
        if (is_load) begin
            wb_code = WB_LOAD;
        end else if (is_jal || is_jalr) begin
            wb_code = WB_PC4;
        end else if (is_lui) begin
            wb_code = WB_IMM;
        end
    end

    // Branch outcome comes from taken_q, captured in EXECUTE where the comparator is valid.
    always_comb begin
        pc_code = PC_PLUS4;
        if (is_jal) begin
            pc_code = PC_REL;
        end else if (is_jalr) begin
            pc_code = PC_JALR;
        end else if (is_branch && taken_q) begin
            pc_code = PC_REL;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        instret_d = instret_q;
        trap_d    = trap_q;
        cause_d   = cause_q;
        mem_op_d  = mem_op_q;
        store_d   = store_q;
        taken_d   = taken_q;
        case (state_q)
            ST_FETCH: begin
                state_d = ST_FETCH_WAIT;
                wait_d  = '0;
            end
            ST_FETCH_WAIT: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_BUS;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_DECODE: begin
                if (dec_illegal) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d  = ST_EXECUTE;
                    mem_op_d = is_mem_opcode(opcode);
                    store_d  = is_store;
                end
            end
            ST_EXECUTE: begin
                taken_d = branch_taken;
                if (mem_op_q) begin
                    state_d = ST_MEM_WAIT;
                    wait_d  = '0;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = ST_WRITEBACK;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_BUS;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_WRITEBACK: begin
                state_d   = ST_FETCH;
                instret_d = instret_q + CNT_W'(1);
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            wait_q    <= '0;
            instret_q <= '0;
            trap_q    <= 1'b0;
            cause_q   <= CAUSE_NONE;
            mem_op_q  <= 1'b0;
            store_q   <= 1'b0;
            taken_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
            mem_op_q  <= mem_op_d;
            store_q   <= store_d;
            taken_q   <= taken_d;
        end
    end

    // ir_load follows mem_ready directly: read data is only guaranteed in that cycle.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_load      = 1'b0;
        pc_sel       = PC_HOLD;
        alu_op       = ALU_ADD;
        alu_src_imm  = 1'b0;
        wb_sel       = WB_ALU;
        rf_we        = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
            end
            ST_FETCH_WAIT: begin
                mem_req = 1'b1;
                ir_load = mem_ready;
            end
            ST_EXECUTE, ST_MEM_WAIT: begin
                mem_req      = mem_op_q;
                mem_we       = store_q;
                mem_addr_sel = is_load || is_store;
                alu_op       = dec_alu_op;
                alu_src_imm  = src_imm;
            end
            ST_WRITEBACK: begin
                alu_op      = dec_alu_op;
                alu_src_imm = src_imm;
                wb_sel      = wb_code;
                rf_we       = !(is_store || is_branch);
                pc_sel      = pc_code;
            end
            default: ;
        endcase
        // Reset is synchronous, so the registers only clear at the next edge;
        // blank the outputs immediately so an aborted request never commits.
        if (reset) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_load      = 1'b0;
            pc_sel       = PC_HOLD;
            alu_op       = ALU_ADD;
            alu_src_imm  = 1'b0;
            wb_sel       = WB_ALU;
            rf_we        = 1'b0;
        end
    end

    assign trap       = trap_q && !reset;
    assign trap_cause = reset ? CAUSE_NONE : cause_q;
    assign instret    = reset ? '0 : instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized self-checking bench: an instruction-level model predicts every
// output in every cycle of each instruction's fetch/decode/execute/wait/write-back.
module tb_multicycle_sequencer;

    localparam int TB_CNT_W    = 4;
    localparam int TB_MAX_WAIT = 15;

    logic                clk;
    logic                reset;
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic                branch_taken;
    logic                mem_ready;
    logic                mem_req;
    logic                mem_we;
    logic                mem_addr_sel;
    logic                ir_load;
    logic [1:0]          pc_sel;
    logic [3:0]          alu_op;
    logic                alu_src_imm;
    logic [1:0]          wb_sel;
    logic                rf_we;
    logic                trap;
    logic [1:0]          trap_cause;
    logic [TB_CNT_W-1:0] instret;

    multicycle_sequencer #(
        .XLEN    (32),
        .CNT_W   (TB_CNT_W),
        .MAX_WAIT(TB_MAX_WAIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .branch_taken(branch_taken),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr_sel(mem_addr_sel),
        .ir_load     (ir_load),
        .pc_sel      (pc_sel),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .wb_sel      (wb_sel),
        .rf_we       (rf_we),
        .trap        (trap),
        .trap_cause  (trap_cause),
        .instret     (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // What the ISA says about one instruction.
    typedef struct packed {
        bit       legal;
        bit [3:0] alu;
        bit       src_imm;
        bit [1:0] wb;
        bit       writes;
        bit       is_mem;
        bit       is_store;
        bit [1:0] kind;     // 0 sequential, 1 branch, 2 jal, 3 jalr
    } info_t;

    typedef struct packed {
        bit       mem_req;
        bit       mem_we;
        bit       addr_sel;
        bit       ir_load;
        bit [1:0] pc_sel;
        bit [3:0] alu;
        bit       src;
        bit [1:0] wb;
        bit       rf_we;
        bit       trap;
        bit [1:0] cause;
        int       instret;
    } exp_t;

    int checks   = 0;
    int failures = 0;
    int n_insn   = 0;
    int m_instret;
    bit m_trap;
    bit [1:0] m_cause;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (insn %0d, t=%0t)", tag, act, exp, n_insn, $time);
        end
    endtask

    // ALU codes: ADD0 SUB1 AND2 OR3 XOR4 SLT5 SLTU6 SLL7 SRL8 SRA9
    function automatic info_t ref_info(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
        logic [3:0] f3map [8];
        info_t r;
        f3map = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        r = '0;
        r.legal   = 1'b1;
        r.writes  = 1'b1;
        r.src_imm = 1'b1;
        case (opc)
            7'b0110011: begin
                r.src_imm = 1'b0;
                r.alu = f3map[f3];
                if (f7 == 7'h20 && f3 == 3'd0) r.alu = 4'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) r.alu = 4'd9;
                else if (f7 != 7'h00) r.legal = 1'b0;
            end
            7'b0010011: begin
                r.alu = f3map[f3];
                if (f3 == 3'd1 && f7 != 7'h00) r.legal = 1'b0;
                if (f3 == 3'd5) begin
                    if (f7 == 7'h20) r.alu = 4'd9;
                    else if (f7 != 7'h00) r.legal = 1'b0;
                end
            end
            7'b0000011: begin r.wb = 2'd1; r.is_mem = 1'b1; end
            7'b0100011: begin r.writes = 1'b0; r.is_mem = 1'b1; r.is_store = 1'b1; end
            7'b1100011: begin r.writes = 1'b0; r.src_imm = 1'b0; r.alu = 4'd1; r.kind = 2'd1; end
            7'b1101111: begin r.wb = 2'd2; r.kind = 2'd2; end
            7'b1100111: begin r.wb = 2'd2; r.kind = 2'd3; end
            7'b0110111: r.wb = 2'd3;
            7'b0010111: r.wb = 2'd0;
            default:    r.legal = 1'b0;
        endcase
        return r;
    endfunction

    function automatic exp_t idle();
        exp_t e;
        e = '0;
        e.trap    = m_trap;
        e.cause   = m_cause;
        e.instret = m_instret;
        return e;
    endfunction

    task automatic compare_all(input string ph, input exp_t e);
        check_eq({ph, ".mem_req"},  32'(mem_req),      32'(e.mem_req));
        check_eq({ph, ".mem_we"},   32'(mem_we),       32'(e.mem_we));
        check_eq({ph, ".addr_sel"}, 32'(mem_addr_sel), 32'(e.addr_sel));
        check_eq({ph, ".ir_load"},  32'(ir_load),      32'(e.ir_load));
        check_eq({ph, ".pc_sel"},   32'(pc_sel),       32'(e.pc_sel));
        check_eq({ph, ".alu_op"},   32'(alu_op),       32'(e.alu));
        check_eq({ph, ".src_imm"},  32'(alu_src_imm),  32'(e.src));
        check_eq({ph, ".wb_sel"},   32'(wb_sel),       32'(e.wb));
        check_eq({ph, ".rf_we"},    32'(rf_we),        32'(e.rf_we));
        check_eq({ph, ".trap"},     32'(trap),         32'(e.trap));
        check_eq({ph, ".cause"},    32'(trap_cause),   32'(e.cause));
        check_eq({ph, ".instret"},  32'(instret),      32'(e.instret));
    endtask

    // Inputs are set just after a rising edge; outputs are sampled 2 time units later.
    task automatic cycle(input string ph, input exp_t e);
        #2;
        compare_all(ph, e);
        @(posedge clk);
        #1;
    endtask

    task automatic junk_ir();
        opcode = 7'($urandom);
        funct3 = 3'($urandom);
        funct7 = 7'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            junk_ir();
            mem_ready    = 1'($urandom);
            branch_taken = 1'($urandom);
            cycle("reset", exp_t'(0));
        end
        m_instret = 0;
        m_trap    = 1'b0;
        m_cause   = 2'd0;
        reset     = 1'b0;
    endtask

    task automatic trap_hold();
        for (int i = 0; i < 20; i++) begin
            junk_ir();
            mem_ready    = 1'($urandom);
            branch_taken = 1'($urandom);
            cycle("trap", idle());
        end
        $display("insn %0d trapped cause=%0d instret=%0d", n_insn, m_cause, m_instret);
        do_reset();
    endtask

    // bt_mode: 0/1 forces branch_taken in EXECUTE, anything else randomizes it.
    // rst_mw: MEM_WAIT cycle index in which reset is asserted, -1 for none.
    task automatic run_insn(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                            input int fw, input int mw, input int bt_mode, input int rst_mw);
        info_t inf;
        exp_t  e;
        logic  bt;
        inf = ref_info(opc, f3, f7);
        n_insn++;

        junk_ir();
        mem_ready    = 1'($urandom);
        branch_taken = 1'($urandom);
        e = idle();
        e.mem_req = 1'b1;
        cycle("fetch", e);

        for (int k = 0; k <= TB_MAX_WAIT; k++) begin
            junk_ir();
            mem_ready    = (k == fw);
            branch_taken = 1'($urandom);
            e = idle();
            e.mem_req = 1'b1;
            e.ir_load = (k == fw);
            cycle("fetch_wait", e);
            if (k == fw) break;
        end
        if (fw > TB_MAX_WAIT) begin
            m_trap  = 1'b1;
            m_cause = 2'd2;
            trap_hold();
            return;
        end

        opcode       = opc;
        funct3       = f3;
        funct7       = f7;
        mem_ready    = 1'($urandom);
        branch_taken = 1'($urandom);
        cycle("decode", idle());
        if (!inf.legal) begin
            m_trap  = 1'b1;
            m_cause = 2'd1;
            trap_hold();
            return;
        end

        bt           = (bt_mode == 0 || bt_mode == 1) ? 1'(bt_mode) : 1'($urandom);
        branch_taken = bt;
        mem_ready    = 1'($urandom);
        e = idle();
        e.mem_req  = inf.is_mem;
        e.mem_we   = inf.is_store;
        e.addr_sel = inf.is_mem;
        e.alu      = inf.alu;
        e.src      = inf.src_imm;
        cycle("execute", e);

        if (inf.is_mem) begin
            for (int k = 0; k <= TB_MAX_WAIT; k++) begin
                if (k == rst_mw) begin
                    reset     = 1'b1;
                    mem_ready = 1'($urandom);
                    cycle("reset_mid_wait", exp_t'(0));
                    reset     = 1'b0;
                    m_instret = 0;
                    m_trap    = 1'b0;
                    m_cause   = 2'd0;
                    $display("insn %0d aborted by reset in mem wait", n_insn);
                    return;
                end
                mem_ready    = (k == mw);
                branch_taken = 1'($urandom);
                e = idle();
                e.mem_req  = 1'b1;
                e.mem_we   = inf.is_store;
                e.addr_sel = 1'b1;
                e.alu      = inf.alu;
                e.src      = inf.src_imm;
                cycle("mem_wait", e);
                if (k == mw) break;
            end
            if (mw > TB_MAX_WAIT) begin
                m_trap  = 1'b1;
                m_cause = 2'd2;
                trap_hold();
                return;
            end
        end

        branch_taken = 1'($urandom);
        mem_ready    = 1'($urandom);
        e = idle();
        e.alu    = inf.alu;
        e.src    = inf.src_imm;
        e.wb     = inf.wb;
        e.rf_we  = inf.writes;
        case (inf.kind)
            2'd1:    e.pc_sel = bt ? 2'b10 : 2'b01;
            2'd2:    e.pc_sel = 2'b10;
            2'd3:    e.pc_sel = 2'b11;
            default: e.pc_sel = 2'b01;
        endcase
        cycle("writeback", e);
        m_instret = (m_instret + 1) % (1 << TB_CNT_W);
        $display("insn %0d opc=%b f3=%b f7=%b fw=%0d mw=%0d bt=%0d retired instret=%0d",
                 n_insn, opc, f3, f7, fw, mw, bt, m_instret);
    endtask

    function automatic int rand_wait();
        int r;
        r = int'($urandom_range(0, 19));
        return (r < 16) ? (r % 4) : (TB_MAX_WAIT - 1 + (r - 16));
    endfunction

    initial begin
        logic [6:0] opcs [9];
        logic [6:0] opc;
        logic [6:0] f7;
        int         sel;
        int         rmw;
        opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        reset = 1'b1;
        opcode = '0;
        funct3 = '0;
        funct7 = '0;
        branch_taken = 1'b0;
        mem_ready = 1'b0;
        m_instret = 0;
        m_trap = 1'b0;
        m_cause = 2'd0;
        @(posedge clk);
        #1;
        do_reset();

        // ADDI x1,x0,5 with zero-wait memory; the following fetch sees instret = 1
        run_insn(7'b0010011, 3'b000, 7'b0000000, 0, 0, 2, -1);
        // LW with three empty MEM_WAIT cycles
        run_insn(7'b0000011, 3'b010, 7'b0000000, 0, 3, 2, -1);
        // BEQ taken / not taken
        run_insn(7'b1100011, 3'b000, 7'b0000000, 0, 0, 1, -1);
        run_insn(7'b1100011, 3'b000, 7'b0000000, 0, 0, 0, -1);
        // Wait limit boundaries: ready on the last count wins, one later traps
        run_insn(7'b0110011, 3'b000, 7'b0100000, TB_MAX_WAIT, 0, 2, -1);
        run_insn(7'b0100011, 3'b010, 7'b0000000, 0, TB_MAX_WAIT, 2, -1);
        run_insn(7'b0110011, 3'b111, 7'b0000000, TB_MAX_WAIT + 1, 0, 2, -1);
        run_insn(7'b0000011, 3'b000, 7'b0000000, 1, TB_MAX_WAIT + 1, 2, -1);
        // Illegal opcode and illegal shift funct7
        run_insn(7'b0000000, 3'b000, 7'b0000000, 0, 0, 2, -1);
        run_insn(7'b0010011, 3'b001, 7'b0100000, 0, 0, 2, -1);
        // 16 retirements wrap a 4-bit counter back to zero
        do_reset();
        for (int i = 0; i < 16; i++) run_insn(7'b0010011, 3'b000, 7'b0000000, 0, 0, 2, -1);
        // Reset in the middle of MEM_WAIT, then the next instruction starts at FETCH
        run_insn(7'b0000011, 3'b010, 7'b0000000, 0, 5, 2, 2);
        run_insn(7'b1101111, 3'b000, 7'b0000000, 0, 0, 2, -1);

        for (int i = 0; i < 150; i++) begin
            sel = int'($urandom_range(0, 10));
            opc = (sel < 9) ? opcs[sel] : 7'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: f7 = 7'h00;
                4, 5, 6:    f7 = 7'h20;
                default:    f7 = 7'($urandom);
            endcase
            rmw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) : -1;
            run_insn(opc, 3'($urandom), f7, rand_wait(), rand_wait(), 2, rmw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
